vram_ctrl: RTL and testbench

- Responder side of the PPU's VRAM read interface. Owns the 8 KiB VRAM as 2048 x 32-bit words.
- PPU reads (13-bit byte address, full 32-bit word returned) have absolute priority.
- CPU reads and byte-masked writes arrive on a req/ready port. Writes are posted into a small write buffer and drained in cycles the PPU leaves idle.
- Sits between the CPU bus decoder and the PPU. Single clock domain.

---
 rtl/vram_ctrl.sv | 139 +++++++++++++
 tb/tb_vram_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_ctrl.sv
// VRAM responder: 2048 x 32-bit words, PPU reads first, CPU writes posted through a small buffer.
// Optional build macro VRAM_CLEAR_EN zeroes the whole VRAM after every reset before serving the CPU.
module vram_ctrl #(
  parameter int unsigned WBUF_DEPTH = 4,
  parameter int unsigned ADDR_W     = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ppu_rd_en,
  input  logic [ADDR_W-1:0] ppu_addr,
  output logic [31:0]       ppu_data,
  output logic              ppu_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [3:0]        cpu_be,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ready,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_rvalid,
  output logic [2:0]        wbuf_level
);
  localparam int unsigned IDX_W   = ADDR_W - 2;
  localparam int unsigned WORDS   = 1 << IDX_W;
  localparam int unsigned PTR_W   = $clog2(WBUF_DEPTH);
  localparam logic [2:0]  DEPTH_L = 3'(WBUF_DEPTH);
`ifdef VRAM_CLEAR_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
`endif

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t           state_q, state_d;
`ifdef VRAM_CLEAR_EN
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
`endif

  logic [31:0]      mem [WORDS];
  logic [IDX_W-1:0] wb_idx  [WBUF_DEPTH];
  logic [3:0]       wb_be   [WBUF_DEPTH];
  logic [31:0]      wb_data [WBUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  logic [IDX_W-1:0] ppu_idx, cpu_idx;
  logic             run, wr_ok, rd_ok, push, pop, cpu_rd_acc;
  logic             unused_addr_bits;

  assign ppu_idx          = ppu_addr[ADDR_W-1:2];
  assign cpu_idx          = cpu_addr[ADDR_W-1:2];
  assign unused_addr_bits = ^{ppu_addr[1:0], cpu_addr[1:0]};

  // Port arbitration: PPU read > CPU read > buffer drain; reads require an empty buffer
  always_comb begin
    run        = (state_q == ST_RUN);
    wr_ok      = run && (wbuf_level < DEPTH_L);
    rd_ok      = run && (wbuf_level == 3'd0) && !ppu_rd_en && !cpu_rvalid;
    cpu_ready  = !rst && (cpu_we ? wr_ok : rd_ok);
    push       = cpu_req && cpu_we && cpu_ready;
    cpu_rd_acc = cpu_req && !cpu_we && cpu_ready;
    pop        = run && !ppu_rd_en && !cpu_rd_acc && (wbuf_level != 3'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef VRAM_CLEAR_EN
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
`else
      state_q   <= ST_RUN;
`endif
    end else begin
      state_q   <= state_d;
`ifdef VRAM_CLEAR_EN
      clr_idx_q <= clr_idx_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
`ifdef VRAM_CLEAR_EN
    clr_idx_d = clr_idx_q;
`endif
    unique case (state_q)
      ST_CLEAR: begin
`ifdef VRAM_CLEAR_EN
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_IDX) state_d = ST_RUN;
`else
        state_d = ST_RUN;
`endif
      end
      ST_RUN: state_d = ST_RUN;
    endcase
  end

  // Read returns, buffer pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ppu_data   <= '0;
      ppu_valid  <= 1'b0;
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      wbuf_level <= '0;
    end else begin
      ppu_valid  <= ppu_rd_en;
      if (ppu_rd_en) ppu_data <= run ? mem[ppu_idx] : '0;
      cpu_rvalid <= cpu_rd_acc;
      if (cpu_rd_acc) cpu_rdata <= mem[cpu_idx];
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      wbuf_level <= wbuf_level + 3'd1;
      else if (pop && !push) wbuf_level <= wbuf_level - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wb_idx[wr_ptr]  <= cpu_idx;
      wb_be[wr_ptr]   <= cpu_be;
      wb_data[wr_ptr] <= cpu_wdata;
    end
  end

  // Single write port: clear sweep or byte-masked drain of the buffer head
  always_ff @(posedge clk) begin
`ifdef VRAM_CLEAR_EN
    if (state_q == ST_CLEAR) mem[clr_idx_q] <= '0;
    else
`endif
    if (pop) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_be[rd_ptr][b]) mem[wb_idx[rd_ptr]][8*b +: 8] <= wb_data[rd_ptr][8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_vram_ctrl.sv
// Bench for vram_ctrl: directed steps plus random traffic against a word-array/queue reference model.
// Also covers the VRAM_CLEAR_EN build when that macro is defined.
module tb_vram_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ppu_rd_en = 1'b0;
  logic [12:0] ppu_addr = '0;
  logic [31:0] ppu_data;
  logic        ppu_valid;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [12:0] cpu_addr = '0;
  logic [3:0]  cpu_be = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;
  logic [2:0]  wbuf_level;

  always #5 clk = ~clk;

  vram_ctrl dut (
    .clk(clk), .rst(rst),
    .ppu_rd_en(ppu_rd_en), .ppu_addr(ppu_addr), .ppu_data(ppu_data), .ppu_valid(ppu_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid), .wbuf_level(wbuf_level)
  );

  typedef struct {
    int          idx;
    logic [3:0]  be;
    logic [31:0] data;
  } wentry_t;

  logic [31:0] vm [2048];
  wentry_t     wq [$];
  logic        exp_pv = 1'b0, exp_cv = 1'b0;
  logic [31:0] exp_pd = '0, exp_cd = '0;
  logic        last_acc = 1'b0, obs_acc = 1'b0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                        input logic [31:0] d);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  // One clock: check outputs at the falling edge, then advance the model with this cycle's inputs
  task automatic cycle();
    logic    rdy;
    wentry_t e;
    @(negedge clk);
    chk("ppu_valid", 32'(ppu_valid), 32'(exp_pv));
    if (exp_pv) chk("ppu_data", ppu_data, exp_pd);
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_cv));
    if (exp_cv) chk("cpu_rdata", cpu_rdata, exp_cd);
    chk("wbuf_level", 32'(wbuf_level), wq.size());
    rdy = cpu_we ? (wq.size() < 4) : (wq.size() == 0 && !ppu_rd_en && !exp_cv);
    chk("cpu_ready", 32'(cpu_ready), 32'(rdy));
    last_acc = cpu_req && rdy;
    obs_acc  = cpu_req && cpu_ready;
    exp_pv = ppu_rd_en;
    if (ppu_rd_en) exp_pd = vm[ppu_addr[12:2]];
    exp_cv = last_acc && !cpu_we;
    if (exp_cv) exp_cd = vm[cpu_addr[12:2]];
    if (!ppu_rd_en && !exp_cv && wq.size() > 0) begin
      e = wq.pop_front();
      vm[e.idx] = merge(vm[e.idx], e.be, e.data);
    end
    if (last_acc && cpu_we) wq.push_back('{int'(cpu_addr[12:2]), cpu_be, cpu_wdata});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ppu_rd_en = 1'b0;
    cpu_req   = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic cpu_write(input logic [12:0] a, input logic [3:0] be, input logic [31:0] d);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_be = be; cpu_wdata = d;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (last_acc) break;
    end
    chk("wr_accept", 32'(obs_acc), 32'd1);
    cpu_req = 1'b0;
  endtask

  task automatic cpu_read(input logic [12:0] a);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (last_acc) break;
    end
    chk("rd_accept", 32'(obs_acc), 32'd1);
    cpu_req = 1'b0;
  endtask

  task automatic ppu_read(input logic [12:0] a);
    ppu_rd_en = 1'b1;
    ppu_addr  = a;
    cycle();
    ppu_rd_en = 1'b0;
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    cpu_req = 1'b0;
    cpu_we  = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cpu_ready) break;
      n++;
    end
    @(posedge clk);
    #1;
    cpu_we = 1'b0;
  endtask

  // Called one time unit after a rising edge; asserts rst mid-cycle and checks the async clear
  task automatic do_reset();
    int n;
    #2 rst = 1'b1;
    ppu_rd_en = 1'b0; cpu_req = 1'b0; cpu_we = 1'b1;
    #1;
    chk("rst_ppu_data", ppu_data, 32'h0);
    chk("rst_ppu_valid", 32'(ppu_valid), 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    chk("rst_cpu_ready", 32'(cpu_ready), 32'h0);
    chk("rst_wbuf_level", 32'(wbuf_level), 32'h0);
    wq.delete();
    exp_pv = 1'b0;
    exp_cv = 1'b0;
    cpu_we = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
`ifdef VRAM_CLEAR_EN
    wait_clear(n);
    chk("clear_cycles", n, 32'd2048);
    foreach (vm[i]) vm[i] = '0;
`else
    n = 0;
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] words [16];
    int          j;
    for (int i = 0; i < 14; i++) words[i] = 13'h1400 + 13'(4 * i);
    words[14] = 13'h1800;
    words[15] = 13'h1FFC;

    do_reset();
    for (int i = 0; i < 16; i++) cpu_write(words[i], 4'hF, $urandom);
    idle(2);

    // PPU sees a drained write, one cycle after its request
    cpu_write(13'h1800, 4'hF, 32'hDEADBEEF);
    idle(2);
    ppu_read(13'h1802);
    chk("t1_ppu_valid", 32'(ppu_valid), 32'd1);
    chk("t1_ppu_data", ppu_data, 32'hDEADBEEF);
    idle(1);

    // Single-lane write merges into an existing word
    cpu_write(13'h1400, 4'hF, 32'h11223344);
    cpu_write(13'h1400, 4'b0010, 32'h0000AA00);
    idle(2);
    cpu_read(13'h1400);
    chk("t2_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("t2_cpu_rdata", cpu_rdata, 32'h1122AA44);
    idle(1);

    // Sustained PPU reads fill the buffer; the fifth write waits, then drains last
    ppu_rd_en = 1'b1;
    ppu_addr  = 13'h1804;
    for (int i = 0; i < 4; i++) cpu_write(13'h1420 + 13'(4 * i), 4'hF, 32'hA5A50000 + 32'(i));
    chk("t3_level_full", 32'(wbuf_level), 32'd4);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1420; cpu_be = 4'hF; cpu_wdata = 32'h5A5A5A5A;
    repeat (3) begin
      cycle();
      chk("t3_blocked_ready", 32'(cpu_ready), 32'd0);
      chk("t3_blocked_level", 32'(wbuf_level), 32'd4);
    end
    ppu_rd_en = 1'b0;
    cpu_write(13'h1420, 4'hF, 32'h5A5A5A5A);
    idle(5);
    chk("t3_level_empty", 32'(wbuf_level), 32'd0);
    ppu_read(13'h1420);
    chk("t3_fifth_last", ppu_data, 32'h5A5A5A5A);
    for (int i = 1; i < 4; i++) begin
      ppu_read(13'h1420 + 13'(4 * i));
      chk("t3_word", ppu_data, 32'hA5A50000 + 32'(i));
    end
    idle(1);

    // CPU read waits behind buffered writes and then observes them
    ppu_rd_en = 1'b1;
    ppu_addr  = 13'h1808;
    cpu_write(13'h1430, 4'hF, 32'hC0FFEE01);
    cpu_write(13'h1434, 4'hF, 32'hC0FFEE02);
    chk("t4_level", 32'(wbuf_level), 32'd2);
    ppu_rd_en = 1'b0;
    cpu_read(13'h1434);
    chk("t4_cpu_rdata", cpu_rdata, 32'hC0FFEE02);
    idle(1);

    // Random mixed traffic
    for (int k = 0; k < 400; k++) begin
      ppu_rd_en = ($urandom_range(0, 2) == 0);
      j         = int'($urandom_range(0, 15));
      ppu_addr  = words[j] | 13'($urandom_range(0, 3));
      cpu_req   = 1'($urandom);
      cpu_we    = 1'($urandom);
      j         = int'($urandom_range(0, 15));
      cpu_addr  = words[j] | 13'($urandom_range(0, 3));
      cpu_be    = 4'($urandom);
      cpu_wdata = $urandom;
      cycle();
    end
    idle(6);

    // Reset with buffered writes pending: they are dropped, memory untouched
    ppu_rd_en = 1'b1;
    ppu_addr  = 13'h1800;
    for (int i = 0; i < 3; i++) cpu_write(13'h1400 + 13'(4 * i), 4'hF, 32'hBAD00000 + 32'(i));
    chk("t5_level", 32'(wbuf_level), 32'd3);
    do_reset();
    // Reset while a CPU read is being presented: no return pulse afterwards
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h1404;
    do_reset();
    cycle();
    chk("t5_no_rvalid", 32'(cpu_rvalid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      ppu_read(13'h1400 + 13'(4 * i));
      chk("t5_word_kept", ppu_data, vm[11'h500 + 11'(i)]);
    end
    idle(1);

`ifdef VRAM_CLEAR_EN
    // Reset part-way through the sweep restarts the full count
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    do_reset();
    ppu_read(13'h1FFC);
    chk("clr_last_word", ppu_data, 32'h0);
    idle(1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
